// File: rtl/zeroriscy_defines.sv
// Shared definitions for the zeroriscy execute-stage units.
//   MD_OP_*   : multiply/divide operation encodings driven by the decoder
//   md_fsm_e  : state encoding of the iterative multiply/divide sequencer
package zeroriscy_defines;

    localparam logic [1:0] MD_OP_MULL = 2'b00;
    localparam logic [1:0] MD_OP_MULH = 2'b01;
    localparam logic [1:0] MD_OP_DIV  = 2'b10;
    localparam logic [1:0] MD_OP_REM  = 2'b11;

    typedef enum logic [2:0] {
        MD_IDLE,
        MD_ABS,
        MD_CALC,
        MD_FIX,
        MD_FINISH
    } md_fsm_e;

endpackage

// File: rtl/zeroriscy_md_addsub.sv
// Adder/subtractor shared by every step of the multiply/divide sequencer.
//   a_i, b_i   : operands
//   invert_b_i : use ~b_i instead of b_i (with cin_i = 1 this subtracts,
//                and with a_i = 0 it negates b_i)
//   cin_i      : carry in
//   sum_o      : a_i + (b_i or ~b_i) + cin_i, truncated to WIDTH bits
//   carry_o    : carry out; after a subtraction it is 1 when a_i >= b_i
module zeroriscy_md_addsub #(
    parameter int unsigned WIDTH = 33
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             invert_b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
);

    logic [WIDTH-1:0] b_eff;

    always_comb begin
        b_eff = invert_b_i ? ~b_i : b_i;
        {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_i};
    end

endmodule

// File: rtl/zeroriscy_multdiv_seq.sv
// Iterative RV32M multiply/divide sequencer for the EX stage.
//   clk, rst       : clock, synchronous active-high reset
//   multdiv_en_i   : start request, sampled only in IDLE
//   operator_i     : MD_OP_MULL / MD_OP_MULH / MD_OP_DIV / MD_OP_REM
//   signed_mode_i  : bit0 = op_a signed, bit1 = op_b signed
//   op_a_i, op_b_i : multiplicand/dividend, multiplier/divisor
//   kill_i         : abandon the operation in flight
//   busy_o         : high in every non-IDLE state
//   ready_o        : one-cycle result-valid pulse (FINISH)
//   result_o       : result, held until the next FIX->FINISH update
module zeroriscy_multdiv_seq
    import zeroriscy_defines::*;
#(
    parameter int unsigned WIDTH           = 32,
    parameter bit          DIV_ZERO_BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             multdiv_en_i,
    input  logic [1:0]       operator_i,
    input  logic [1:0]       signed_mode_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             kill_i,
    output logic             busy_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    md_fsm_e          state;
    logic [WIDTH-1:0] a_q;       // op_a, then its magnitude after ABS
    logic [WIDTH-1:0] b_mag_q;   // magnitude of op_b
    logic [WIDTH-1:0] hi_q;      // product high half / partial remainder
    logic [WIDTH-1:0] lo_q;      // multiplier -> product low half / dividend -> quotient
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       op_q;
    logic             sign_a_q;
    logic             sign_b_q;

    logic [WIDTH:0]   add_a;
    logic [WIDTH:0]   add_b;
    logic [WIDTH:0]   add_sum;
    logic             add_inv_b;
    logic             add_cin;
    logic             add_carry;

    logic             is_mul;
    logic             start_is_div;
    logic             sign_b_in;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] fix_val;
    logic             fix_neg;

    assign is_mul       = (op_q == MD_OP_MULL) || (op_q == MD_OP_MULH);
    assign start_is_div = (operator_i == MD_OP_DIV) || (operator_i == MD_OP_REM);
    assign sign_b_in    = signed_mode_i[1] & op_b_i[WIDTH-1];
    assign a_abs        = sign_a_q ? add_sum[WIDTH-1:0] : a_q;
    assign div_shift    = {hi_q, lo_q[WIDTH-1]};

    zeroriscy_md_addsub #(
        .WIDTH (WIDTH + 1)
    ) u_addsub (
        .a_i        (add_a),
        .b_i        (add_b),
        .invert_b_i (add_inv_b),
        .cin_i      (add_cin),
        .sum_o      (add_sum),
        .carry_o    (add_carry)
    );

    // The single carry chain is time-shared: op_b is negated while still in
    // IDLE (the adder is otherwise unused there), leaving ABS free for op_a.
    // A 2*WIDTH negation in FIX only ever needs one half: -lo for MULL, and
    // ~hi + (lo == 0) for MULH.
    always_comb begin
        add_a     = '0;
        add_b     = '0;
        add_inv_b = 1'b0;
        add_cin   = 1'b0;
        fix_val   = lo_q;
        fix_neg   = 1'b0;
        case (state)
            MD_IDLE: begin
                add_b     = {1'b0, op_b_i};
                add_inv_b = 1'b1;
                add_cin   = 1'b1;
            end
            MD_ABS: begin
                add_b     = {1'b0, a_q};
                add_inv_b = 1'b1;
                add_cin   = 1'b1;
            end
            MD_CALC: begin
                if (is_mul) begin
                    add_a = {1'b0, hi_q};
                    add_b = lo_q[0] ? {1'b0, a_q} : '0;
                end else begin
                    add_a     = div_shift;
                    add_b     = {1'b0, b_mag_q};
                    add_inv_b = 1'b1;
                    add_cin   = 1'b1;
                end
            end
            MD_FIX: begin
                add_inv_b = 1'b1;
                add_cin   = 1'b1;
                case (op_q)
                    MD_OP_MULL: begin
                        fix_val = lo_q;
                        fix_neg = sign_a_q ^ sign_b_q;
                    end
                    MD_OP_MULH: begin
                        fix_val = hi_q;
                        fix_neg = sign_a_q ^ sign_b_q;
                        add_cin = (lo_q == '0);
                    end
                    MD_OP_DIV: begin
                        fix_val = lo_q;
                        fix_neg = sign_a_q ^ sign_b_q;
                    end
                    default: begin
                        fix_val = hi_q;
                        fix_neg = sign_a_q;
                    end
                endcase
                add_b = {1'b0, fix_val};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= MD_IDLE;
            busy_o   <= 1'b0;
            ready_o  <= 1'b0;
            result_o <= '0;
            a_q      <= '0;
            b_mag_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
        end else if (kill_i) begin
            state   <= MD_IDLE;
            busy_o  <= 1'b0;
            ready_o <= 1'b0;
        end else begin
            ready_o <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (multdiv_en_i) begin
                        a_q      <= op_a_i;
                        b_mag_q  <= sign_b_in ? add_sum[WIDTH-1:0] : op_b_i;
                        op_q     <= operator_i;
                        sign_a_q <= signed_mode_i[0] & op_a_i[WIDTH-1];
                        sign_b_q <= sign_b_in;
                        busy_o   <= 1'b1;
                        if (DIV_ZERO_BYPASS && start_is_div && (op_b_i == '0)) begin
                            result_o <= (operator_i == MD_OP_DIV) ? '1 : op_a_i;
                            ready_o  <= 1'b1;
                            state    <= MD_FINISH;
                        end else begin
                            state <= MD_ABS;
                        end
                    end
                end
                MD_ABS: begin
                    a_q   <= a_abs;
                    lo_q  <= is_mul ? b_mag_q : a_abs;
                    hi_q  <= '0;
                    cnt_q <= CNT_W'(WIDTH - 1);
                    state <= MD_CALC;
                end
                MD_CALC: begin
                    if (is_mul) begin
                        hi_q <= add_sum[WIDTH:1];
                        lo_q <= {add_sum[0], lo_q[WIDTH-1:1]};
                    end else begin
                        // carry out of the subtraction means remainder >= divisor
                        hi_q <= add_carry ? add_sum[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        lo_q <= {lo_q[WIDTH-2:0], add_carry};
                    end
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        state <= MD_FIX;
                    end
                end
                MD_FIX: begin
                    result_o <= fix_neg ? add_sum[WIDTH-1:0] : fix_val;
                    ready_o  <= 1'b1;
                    state    <= MD_FINISH;
                end
                MD_FINISH: begin
                    busy_o <= 1'b0;
                    state  <= MD_IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= MD_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zeroriscy_multdiv_seq.sv
// Self-checking bench for zeroriscy_multdiv_seq (WIDTH = 32, bypass on).
// Expected results come from a 64-bit arithmetic model of RV32M.
module tb_zeroriscy_multdiv_seq;
    import zeroriscy_defines::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        kill;
    logic [1:0]  md_op;
    logic [1:0]  mode;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        ready;
    logic [31:0] result;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_exp = '0;

    always #5 clk = ~clk;

    zeroriscy_multdiv_seq #(
        .WIDTH           (32),
        .DIV_ZERO_BYPASS (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .multdiv_en_i  (en),
        .operator_i    (md_op),
        .signed_mode_i (mode),
        .op_a_i        (op_a),
        .op_b_i        (op_b),
        .kill_i        (kill),
        .busy_o        (busy),
        .ready_o       (ready),
        .result_o      (result)
    );

    function automatic logic [31:0] ref_md(input logic [1:0] op, input logic [1:0] md,
                                           input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        sa = md[0] ? longint'(signed'(a)) : longint'(a);
        sb = md[1] ? longint'(signed'(b)) : longint'(b);
        p  = 0;
        case (op)
            MD_OP_MULL: begin p = sa * sb; return p[31:0]; end
            MD_OP_MULH: begin p = sa * sb; return p[63:32]; end
            MD_OP_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = sa / sb;
                return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = sa % sb;
                return p[31:0];
            end
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_inputs();
        md_op = 2'($urandom);
        mode  = 2'($urandom);
        op_a  = $urandom;
        op_b  = $urandom;
    endtask

    // Starts one operation, scrambles the inputs after the start cycle and
    // checks latency, result, busy coverage and the single ready pulse.
    task automatic run_op(input logic [1:0] op, input logic [1:0] md,
                          input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] exp;
        int          exp_lat;
        int          got_lat;
        logic        busy_bad;
        exp     = ref_md(op, md, a, b);
        exp_lat = ((op == MD_OP_DIV || op == MD_OP_REM) && b == 32'd0) ? 1 : 35;
        en = 1'b1; md_op = op; mode = md; op_a = a; op_b = b;
        step();
        en = 1'b0;
        scramble_inputs();
        got_lat  = 0;
        busy_bad = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (busy !== 1'b1) busy_bad = 1'b1;
            if (ready === 1'b1) begin
                got_lat = k;
                break;
            end
            step();
        end
        checks++;
        if (got_lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles, expected %0d", tag, got_lat, exp_lat);
        end
        checks++;
        if (result !== exp) begin
            errors++;
            $display("FAIL %s result: got %h, expected %h", tag, result, exp);
        end
        checks++;
        if (busy_bad !== 1'b0) begin
            errors++;
            $display("FAIL %s busy: busy_o low before ready_o, expected high", tag);
        end
        step();
        checks++;
        if (ready !== 1'b0 || busy !== 1'b0 || result !== exp) begin
            errors++;
            $display("FAIL %s after: ready=%b busy=%b result=%h, expected 0 0 %h",
                     tag, ready, busy, result, exp);
        end
        last_exp = exp;
    endtask

    task automatic test_reset();
        rst = 1'b1; kill = 1'b0; en = 1'b1;
        md_op = MD_OP_MULL; mode = 2'b11; op_a = 32'd9; op_b = 32'd9;
        repeat (3) step();
        checks++;
        if (busy !== 1'b0 || ready !== 1'b0 || result !== 32'd0) begin
            errors++;
            $display("FAIL reset: busy=%b ready=%b result=%h, expected 0 0 0", busy, ready, result);
        end
        rst = 1'b0; en = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_directed();
        run_op(MD_OP_MULL, 2'b11, 32'd7,         32'hFFFF_FFFD, "mull_7x-3");
        run_op(MD_OP_MULH, 2'b11, 32'h8000_0000, 32'h8000_0000, "mulh_min_sq");
        run_op(MD_OP_MULH, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_ones");
        run_op(MD_OP_MULH, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ones");
        run_op(MD_OP_DIV,  2'b11, 32'hFFFF_FFF9, 32'd2,         "div_-7_2");
        run_op(MD_OP_REM,  2'b11, 32'hFFFF_FFF9, 32'd2,         "rem_-7_2");
        run_op(MD_OP_DIV,  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(MD_OP_REM,  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
        run_op(MD_OP_DIV,  2'b11, 32'd5,         32'd0,         "div_by0");
        run_op(MD_OP_REM,  2'b11, 32'd5,         32'd0,         "rem_by0");
    endtask

    task automatic test_kill();
        // kill in CALC: no ready, result unchanged, unit reusable at once
        en = 1'b1; md_op = MD_OP_MULL; mode = 2'b00; op_a = 32'h1234; op_b = 32'h5678;
        step();
        en = 1'b0;
        repeat (9) step();
        kill = 1'b1;
        step();
        kill = 1'b0;
        checks++;
        if (busy !== 1'b0 || ready !== 1'b0 || result !== last_exp) begin
            errors++;
            $display("FAIL kill_calc: busy=%b ready=%b result=%h, expected 0 0 %h",
                     busy, ready, result, last_exp);
        end
        run_op(MD_OP_MULL, 2'b00, 32'd3, 32'd4, "mull_after_kill");

        // kill in FIX beats the move to FINISH
        en = 1'b1; md_op = MD_OP_DIV; mode = 2'b11; op_a = 32'd100; op_b = 32'd7;
        step();
        en = 1'b0;
        repeat (33) step();
        kill = 1'b1;
        step();
        kill = 1'b0;
        checks++;
        if (busy !== 1'b0 || ready !== 1'b0 || result !== last_exp) begin
            errors++;
            $display("FAIL kill_fix: busy=%b ready=%b result=%h, expected 0 0 %h",
                     busy, ready, result, last_exp);
        end

        // kill together with a start request in IDLE: nothing starts
        en = 1'b1; kill = 1'b1; md_op = MD_OP_MULL; op_a = 32'd2; op_b = 32'd2;
        step();
        en = 1'b0; kill = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL kill_idle: busy=%b ready=%b, expected 0 0", busy, ready);
        end
    endtask

    task automatic test_rst_mid();
        en = 1'b1; md_op = MD_OP_REM; mode = 2'b11; op_a = 32'hDEAD_BEEF; op_b = 32'd77;
        step();
        en = 1'b0;
        repeat (14) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || ready !== 1'b0 || result !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid: busy=%b ready=%b result=%h, expected 0 0 0", busy, ready, result);
        end
        last_exp = '0;
        run_op(MD_OP_DIV, 2'b11, 32'hFFFF_FF00, 32'd16, "div_after_rst");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  op;
            logic [1:0]  md;
            logic [31:0] a;
            logic [31:0] b;
            int          sel;
            op  = 2'($urandom);
            md  = 2'($urandom);
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = 32'd0;
            if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (sel == 2) b = $urandom_range(1, 15);
            run_op(op, md, a, b, $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2, exp1, exp2;
        int          pulses;
        int          k1, k2;
        logic [31:0] r1, r2;
        logic        idle_gap_ok;
        a1 = $urandom; b1 = $urandom | 32'd1;
        a2 = $urandom; b2 = $urandom | 32'd1;
        exp1 = ref_md(MD_OP_MULH, 2'b11, a1, b1);
        exp2 = ref_md(MD_OP_DIV,  2'b10, a2, b2);
        en = 1'b1; md_op = MD_OP_MULH; mode = 2'b11; op_a = a1; op_b = b1;
        step();
        md_op = MD_OP_DIV; mode = 2'b10; op_a = a2; op_b = b2;
        pulses = 0; k1 = 0; k2 = 0; r1 = '0; r2 = '0; idle_gap_ok = 1'b1;
        for (int k = 1; k <= 90; k++) begin
            if (k == 36 && busy !== 1'b0) idle_gap_ok = 1'b0;
            if (k == 37 && busy !== 1'b1) idle_gap_ok = 1'b0;
            if (ready === 1'b1) begin
                pulses++;
                if (pulses == 1) begin k1 = k; r1 = result; end
                if (pulses == 2) begin k2 = k; r2 = result; en = 1'b0; end
            end
            step();
        end
        en = 1'b0;
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL b2b_pulses: got %0d ready pulses, expected 2", pulses);
        end
        checks++;
        if (k1 != 35 || k2 != 71) begin
            errors++;
            $display("FAIL b2b_timing: ready at %0d and %0d, expected 35 and 71", k1, k2);
        end
        checks++;
        if (r1 !== exp1 || r2 !== exp2) begin
            errors++;
            $display("FAIL b2b_results: got %h %h, expected %h %h", r1, r2, exp1, exp2);
        end
        checks++;
        if (idle_gap_ok !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle_gap: busy not low at 36 / high at 37, expected idle then restart");
        end
        last_exp = exp2;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; kill = 1'b0;
        md_op = '0; mode = '0; op_a = '0; op_b = '0;
        test_reset();
        test_directed();
        test_kill();
        test_rst_mid();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
